// File: rtl/mode_arbiter_pkg.sv
// Shared types and default constants for the mode arbiter.
//   state_t     : FSM state encoding (also driven out on mode_state)
//   *_DEF       : default parameter values for mode_arbiter
package mode_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EVAL     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned EVAL_W = 4;

  localparam logic [7:0]  CONF_ENTER_DEF      = 8'd32;
  localparam logic [7:0]  RUNLEN_MIN_DEF      = 8'd6;
  localparam int unsigned EVAL_CYCLES_DEF     = 3;
  localparam int unsigned MISS_LIMIT_DEF      = 4;
  localparam int unsigned COOLDOWN_CYCLES_DEF = 8;

endpackage

// File: rtl/arb_down_counter.sv
// Loadable 8-bit down-counter that stops at zero.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (wins over dec)
//   load_val  : value to load
//   dec       : decrement by one (holds at 0)
//   cnt       : current count
//   is_one    : cnt == 1
module arb_down_counter
  import mode_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  // Count register; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst)                       cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (dec && (cnt != '0))   cnt <= cnt - CNT_W'(1);
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/mode_arbiter.sv
// Decides when to switch the pipeline into the adaptive arithmetic mode.
//   clk, rst         : clock, synchronous active-high reset
//   wa_req           : analyzer evaluation request
//   confidence       : analyzer confidence score
//   predicted_runlen : analyzer run-length estimate (arith retires)
//   is_arith_R       : arithmetic instruction retired this cycle
//   pipe_idle        : pipeline drained (acks drain_req)
//   flush            : flush/exception, forces exit
//   drain_req        : high while in DRAIN
//   mode_active      : high while in ACTIVE
//   mode_state       : registered FSM state
//   switch_cnt       : saturating count of completed mode entries
module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter logic [7:0]  CONF_ENTER      = CONF_ENTER_DEF,
  parameter logic [7:0]  RUNLEN_MIN      = RUNLEN_MIN_DEF,
  parameter int unsigned EVAL_CYCLES     = EVAL_CYCLES_DEF,
  parameter int unsigned MISS_LIMIT      = MISS_LIMIT_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wa_req,
  input  logic [7:0] confidence,
  input  logic [7:0] predicted_runlen,
  input  logic       is_arith_R,
  input  logic       pipe_idle,
  input  logic       flush,
  output logic       drain_req,
  output logic       mode_active,
  output logic [2:0] mode_state,
  output logic [7:0] switch_cnt
);

  state_t              state_q, state_d;
  logic [EVAL_W-1:0]   eval_cnt_q, eval_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                switch_inc;
  logic                drain_d, active_d;

  logic                run_load, run_dec, run_is_one;
  logic [CNT_W-1:0]    run_load_val, runlen_cnt, run_after;
  logic                cool_load, cool_dec, cool_is_one;
  logic [CNT_W-1:0]    cool_cnt;
  logic                qualify;

  assign qualify = wa_req && (confidence >= CONF_ENTER) && (predicted_runlen >= RUNLEN_MIN);

  // Remaining run length after this cycle's retire, before any reload.
  assign run_after = (is_arith_R && (runlen_cnt != '0)) ? runlen_cnt - CNT_W'(1) : runlen_cnt;

  arb_down_counter u_runlen (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .load_val (run_load_val),
    .dec      (run_dec),
    .cnt      (runlen_cnt),
    .is_one   (run_is_one)
  );

  arb_down_counter u_cool (
    .clk      (clk),
    .rst      (rst),
    .load     (cool_load),
    .load_val (CNT_W'(COOLDOWN_CYCLES)),
    .dec      (cool_dec),
    .cnt      (cool_cnt),
    .is_one   (cool_is_one)
  );

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      eval_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      switch_cnt  <= '0;
      drain_req   <= 1'b0;
      mode_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      eval_cnt_q  <= eval_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      drain_req   <= drain_d;
      mode_active <= active_d;
      if (switch_inc && (switch_cnt != 8'hFF)) switch_cnt <= switch_cnt + 8'd1;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d      = state_q;
    eval_cnt_d   = eval_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    run_load     = 1'b0;
    run_load_val = predicted_runlen;
    run_dec      = 1'b0;
    cool_load    = 1'b0;
    cool_dec     = 1'b0;
    switch_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (qualify) begin
          eval_cnt_d = EVAL_W'(1);
          if (EVAL_CYCLES == 1) begin
            state_d  = ST_DRAIN;
            run_load = 1'b1;
          end else begin
            state_d  = ST_EVAL;
          end
        end
      end

      ST_EVAL: begin
        if (flush || !qualify) begin
          state_d    = ST_IDLE;
          eval_cnt_d = '0;
        end else if (eval_cnt_q == EVAL_W'(EVAL_CYCLES - 1)) begin
          state_d    = ST_DRAIN;
          eval_cnt_d = '0;
          run_load   = 1'b1;
        end else if (eval_cnt_q != '1) begin
          eval_cnt_d = eval_cnt_q + EVAL_W'(1);
        end
      end

      ST_DRAIN: begin
        if (flush) begin
          state_d   = ST_COOLDOWN;
          cool_load = 1'b1;
        end else if (pipe_idle) begin
          state_d    = ST_ACTIVE;
          switch_inc = 1'b1;
          miss_cnt_d = '0;
        end
      end

      ST_ACTIVE: begin
        if (flush) begin
          state_d    = ST_COOLDOWN;
          cool_load  = 1'b1;
          miss_cnt_d = '0;
        end else begin
          run_dec = is_arith_R;
          // Reload keeps the larger of the remaining and newly predicted run.
          if (qualify) begin
            run_load     = 1'b1;
            run_load_val = (run_after > predicted_runlen) ? run_after : predicted_runlen;
          end
          if (is_arith_R) begin
            miss_cnt_d = '0;
            if (run_is_one && !qualify) begin
              state_d   = ST_COOLDOWN;
              cool_load = 1'b1;
            end
          end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            if ((32'(miss_cnt_q) + 32'd1) >= MISS_LIMIT) begin
              state_d    = ST_COOLDOWN;
              cool_load  = 1'b1;
              miss_cnt_d = '0;
            end
          end
        end
      end

      ST_COOLDOWN: begin
        cool_dec = 1'b1;
        // The ==0 term only guards against a zero-length cooldown setting.
        if (cool_is_one || (cool_cnt == '0)) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs, registered so they line up with state_q.
  always_comb begin
    drain_d  = (state_d == ST_DRAIN);
    active_d = (state_d == ST_ACTIVE);
  end

  assign mode_state = state_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// Directed self-checking bench for mode_arbiter (default parameters).
module tb_mode_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wa_req;
  logic [7:0] confidence;
  logic [7:0] predicted_runlen;
  logic       is_arith_R;
  logic       pipe_idle;
  logic       flush;
  logic       drain_req;
  logic       mode_active;
  logic [2:0] mode_state;
  logic [7:0] switch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mode_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .wa_req           (wa_req),
    .confidence       (confidence),
    .predicted_runlen (predicted_runlen),
    .is_arith_R       (is_arith_R),
    .pipe_idle        (pipe_idle),
    .flush            (flush),
    .drain_req        (drain_req),
    .mode_active      (mode_active),
    .mode_state       (mode_state),
    .switch_cnt       (switch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Qualify for 3 cycles, then acknowledge the drain: ends in ACTIVE.
  task automatic enter(input logic [7:0] run);
    wa_req = 1'b1; confidence = 8'd40; predicted_runlen = run;
    repeat (3) tick();
    wa_req = 1'b0;
    pipe_idle = 1'b1;
    tick();
    pipe_idle = 1'b0;
  endtask

  // Called right after the exit edge; measures COOLDOWN length (bounded).
  task automatic wait_cooldown(input string tag);
    int len;
    len = (mode_state == 3'd4) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mode_state == 3'd4) len++;
      else break;
    end
    check(tag, 32'(len), 32'd8);
  endtask

  initial begin
    rst = 1'b1; wa_req = 1'b0; confidence = 8'd0; predicted_runlen = 8'd0;
    is_arith_R = 1'b0; pipe_idle = 1'b0; flush = 1'b0;
    repeat (2) tick();
    check("rst_state", 32'(mode_state), 32'd0);
    check("rst_drain", 32'(drain_req), 32'd0);
    check("rst_active", 32'(mode_active), 32'd0);
    check("rst_switch", 32'(switch_cnt), 32'd0);
    rst = 1'b0;

    // Entry sequence
    wa_req = 1'b1; confidence = 8'd40; predicted_runlen = 8'd10;
    tick(); check("entry_eval0", 32'(mode_state), 32'd1);
    tick(); check("entry_eval1", 32'(mode_state), 32'd1);
    check("entry_nodrain", 32'(drain_req), 32'd0);
    tick(); check("entry_drain", 32'(drain_req), 32'd1);
    check("entry_drain_st", 32'(mode_state), 32'd2);
    wa_req = 1'b0; pipe_idle = 1'b1;
    tick(); pipe_idle = 1'b0;
    check("entry_active", 32'(mode_active), 32'd1);
    check("entry_drain_off", 32'(drain_req), 32'd0);
    check("entry_switch", 32'(switch_cnt), 32'd1);

    // Miss exit: 4 non-arith cycles
    repeat (3) tick();
    check("miss3_active", 32'(mode_active), 32'd1);
    tick();
    check("miss4_exit", 32'(mode_state), 32'd4);
    check("miss4_inactive", 32'(mode_active), 32'd0);

    // COOLDOWN ignores qualify and lasts 8 cycles
    wa_req = 1'b1; confidence = 8'd200; predicted_runlen = 8'd50;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("cool_hold", 32'(mode_state), 32'd4);
    end
    wa_req = 1'b0;
    tick(); check("cool_done", 32'(mode_state), 32'd0);

    // Broken qualify in the third cycle
    wa_req = 1'b1; confidence = 8'd40; predicted_runlen = 8'd10;
    tick(); check("brk_eval0", 32'(mode_state), 32'd1);
    tick(); check("brk_drain1", 32'(drain_req), 32'd0);
    confidence = 8'd31;
    tick(); check("brk_idle", 32'(mode_state), 32'd0);
    check("brk_drain2", 32'(drain_req), 32'd0);
    wa_req = 1'b0;
    tick(); check("brk_drain3", 32'(drain_req), 32'd0);

    // Runlen exit after 6 arith retires
    enter(8'd6);
    check("rl_switch", 32'(switch_cnt), 32'd2);
    is_arith_R = 1'b1;
    repeat (5) tick();
    check("rl_5_active", 32'(mode_active), 32'd1);
    tick();
    check("rl_6_exit", 32'(mode_active), 32'd0);
    check("rl_6_state", 32'(mode_state), 32'd4);
    is_arith_R = 1'b0;
    wait_cooldown("rl_cool_len");

    // Reload at runlen_cnt==1 cancels exit and loads 20
    enter(8'd6);
    is_arith_R = 1'b1;
    repeat (5) tick();
    wa_req = 1'b1; confidence = 8'd40; predicted_runlen = 8'd20;
    tick();
    wa_req = 1'b0;
    check("rld_stay", 32'(mode_state), 32'd3);
    repeat (19) tick();
    check("rld_19_active", 32'(mode_active), 32'd1);
    tick();
    check("rld_20_exit", 32'(mode_state), 32'd4);
    is_arith_R = 1'b0;
    wait_cooldown("rld_cool_len");
    check("rld_switch", 32'(switch_cnt), 32'd3);

    // flush + pipe_idle in DRAIN
    wa_req = 1'b1; confidence = 8'd40; predicted_runlen = 8'd10;
    repeat (3) tick();
    wa_req = 1'b0;
    check("fl_drain", 32'(drain_req), 32'd1);
    flush = 1'b1; pipe_idle = 1'b1;
    tick();
    flush = 1'b0; pipe_idle = 1'b0;
    check("fl_cool", 32'(mode_state), 32'd4);
    check("fl_switch", 32'(switch_cnt), 32'd3);
    check("fl_inactive", 32'(mode_active), 32'd0);
    wait_cooldown("fl_cool_len");

    // flush in EVAL returns to IDLE
    wa_req = 1'b1;
    tick(); check("fle_eval", 32'(mode_state), 32'd1);
    flush = 1'b1;
    tick(); check("fle_idle", 32'(mode_state), 32'd0);
    wa_req = 1'b0; flush = 1'b0;
    tick();

    // rst in ACTIVE
    enter(8'd10);
    check("ra_active", 32'(mode_active), 32'd1);
    rst = 1'b1;
    tick();
    check("ra_active0", 32'(mode_active), 32'd0);
    check("ra_state0", 32'(mode_state), 32'd0);
    check("ra_drain0", 32'(drain_req), 32'd0);
    check("ra_switch0", 32'(switch_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("ra_after", 32'(mode_state), 32'd0);

    // Saturation after 260 entries
    for (int i = 0; i < 260; i++) begin
      enter(8'd6);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_cooldown("sat_cool_len");
      if (i == 253) check("sat_254", 32'(switch_cnt), 32'd254);
    end
    check("sat_255", 32'(switch_cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mode_arbiter.md
MODE_ARBITER -- requirements
Module: mode_arbiter

Interface
REQ-001 The block SHALL have a parameter CONF_ENTER, default 8'd32, which is the minimum confidence that qualifies a request.
REQ-002 The block SHALL have a parameter RUNLEN_MIN, default 8'd6, which is the minimum predicted_runlen that qualifies a request; legal range is 1..255.
REQ-003 The block SHALL have a parameter EVAL_CYCLES, default 3, which is the number of consecutive qualifying cycles required before drain; legal range is 1..15.
REQ-004 The block SHALL have a parameter MISS_LIMIT, default 4, which is the number of consecutive non-arithmetic retire cycles that forces exit from ACTIVE.
REQ-005 The block SHALL have a parameter COOLDOWN_CYCLES, default 8, which is the exact lockout length after any exit.
REQ-006 clk  input  1  single clock; all logic is rising-edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 wa_req  input  1  evaluation request from the workload analyzer.
REQ-009 confidence  input  8  analyzer confidence score (unsigned).
REQ-010 predicted_runlen  input  8  analyzer run-length estimate, in arithmetic retires.
REQ-011 is_arith_R  input  1  an arithmetic instruction retired this cycle.
REQ-012 pipe_idle  input  1  pipeline drained; acknowledges drain_req.
REQ-013 flush  input  1  flush or exception; forces exit.
REQ-014 drain_req  output  1  request to drain the pipeline before a mode switch.
REQ-015 mode_active  output  1  enables the adaptive arithmetic datapath.
REQ-016 mode_state  output  3  current FSM state encoding.
REQ-017 switch_cnt  output  8  saturating count of completed mode entries.

Function
REQ-018 The signal qualify SHALL be defined as wa_req AND confidence >= CONF_ENTER AND predicted_runlen >= RUNLEN_MIN (unsigned compares).
REQ-019 The FSM SHALL have five states, encoded IDLE=0, EVAL=1, DRAIN=2, ACTIVE=3, COOLDOWN=4; mode_state SHALL equal the registered state.
REQ-020 In IDLE, qualify SHALL load eval_cnt=1; the next state SHALL be DRAIN if EVAL_CYCLES==1, otherwise EVAL.
REQ-021 In EVAL, !qualify SHALL return the FSM to IDLE; qualify with eval_cnt==EVAL_CYCLES-1 SHALL go to DRAIN; otherwise eval_cnt SHALL increment.
REQ-022 On every transition into DRAIN, predicted_runlen SHALL be latched into runlen_cnt.
REQ-023 drain_req SHALL be 1 exactly while the state is DRAIN (Moore output); pipe_idle==1 in DRAIN SHALL go to ACTIVE and increment switch_cnt, saturating at 255.
REQ-024 mode_active SHALL be 1 exactly while the state is ACTIVE.
REQ-025 In ACTIVE, each is_arith_R SHALL decrement runlen_cnt and clear miss_cnt; is_arith_R with runlen_cnt==1 SHALL exit to COOLDOWN.
REQ-026 In ACTIVE, each !is_arith_R cycle SHALL increment miss_cnt; reaching MISS_LIMIT SHALL exit to COOLDOWN.
REQ-027 In ACTIVE, qualify SHALL reload runlen_cnt with max(runlen_cnt_after_decrement, predicted_runlen); a reload in the same cycle as a runlen exit SHALL cancel that exit.
REQ-028 flush SHALL have highest priority: in EVAL it SHALL go to IDLE; in DRAIN or ACTIVE it SHALL go to COOLDOWN, overriding pipe_idle, reload and counter events in the same cycle; in IDLE or COOLDOWN it SHALL have no effect.
REQ-029 Entry to COOLDOWN SHALL load cool_cnt=COOLDOWN_CYCLES; cool_cnt SHALL decrement every cycle, and cool_cnt==1 SHALL go to IDLE, so that COOLDOWN lasts exactly COOLDOWN_CYCLES cycles.
REQ-030 qualify SHALL be ignored in DRAIN and COOLDOWN.
REQ-031 All counters SHALL be narrow saturating or bounded counters that never wrap.

Reset
REQ-032 While rst is 1 at a clock edge, the block SHALL set state=IDLE, drain_req=0, mode_active=0, mode_state=0, switch_cnt=0, and clear eval_cnt, runlen_cnt, miss_cnt and cool_cnt.
REQ-033 Reset asserted in ACTIVE or DRAIN SHALL drop mode_active or drain_req on the same edge, with no cooldown applied.

Structure
REQ-034 Package mode_arbiter_pkg SHALL hold the state enum, its encodings, and the default parameter constants.
REQ-035 Sub-module arb_down_counter (loadable 8-bit down-counter with a ==1 flag) SHALL be instantiated once for runlen_cnt and once for cool_cnt; all other logic SHALL be in mode_arbiter.

Verification
REQ-036 Entry: wa_req=1, confidence=40, runlen=10 held for 3 cycles, then pipe_idle=1 -> drain_req high on cycle 3; mode_active high the following cycle; switch_cnt=1.
REQ-037 Broken qualify: qualify on cycles 0 and 1, confidence=31 on cycle 2 -> FSM returns to IDLE and drain_req never asserts.
REQ-038 Runlen exit: latched runlen=6 and 6 is_arith_R pulses -> mode_active falls after the 6th pulse; COOLDOWN lasts exactly 8 cycles and ignores qualify.
REQ-039 Miss exit and reload: 4 consecutive non-arith cycles -> exit; separately, runlen_cnt=1 with is_arith_R and qualify (runlen=20) in the same cycle -> stays ACTIVE with runlen_cnt=20.
REQ-040 Priority: flush and pipe_idle in the same DRAIN cycle -> COOLDOWN with switch_cnt unchanged; rst in ACTIVE -> all outputs 0 on the next edge.
REQ-041 Saturation: 260 complete entry/exit cycles -> switch_cnt=255.
